// File: rtl/max_posibility_finder.sv
// Scans the POS_num entries of an external probability store and reports the
// largest value and its index. One entry is read per cycle via chose_index/P_in.
module max_posibility_finder #(
  parameter int p_size      = 32,
  parameter int POS_num     = 11,
  parameter int POS_num_bit = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [p_size-1:0]      P_in,
  output logic [POS_num_bit-1:0] chose_index,
  output logic                   busy,
  output logic                   done,
  output logic [p_size-1:0]      max_value,
  output logic [POS_num_bit-1:0] max_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [POS_num_bit-1:0] LAST_IDX = POS_num_bit'(POS_num - 1);

  state_t                 state_q, state_d;
  logic [POS_num_bit-1:0] idx_q, idx_d;
  logic [p_size-1:0]      max_value_q, max_value_d;
  logic [POS_num_bit-1:0] max_index_q, max_index_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_value_q <= max_value_d;
      max_index_q <= max_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    max_value_d = max_value_q;
    max_index_d = max_index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Index 0 seeds the running max; strict > keeps the lower index on ties.
        if ((idx_q == '0) || (P_in > max_value_q)) begin
          max_value_d = P_in;
          max_index_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from flops so reset clears them without a clock.
  assign chose_index = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign max_value   = max_value_q;
  assign max_index   = max_index_q;

endmodule

// File: tb/tb_max_posibility_finder.sv
// Directed bench for max_posibility_finder: a forked monitor pops expected
// results from a scoreboard queue whenever done is seen.
module tb_max_posibility_finder;
  localparam int PS  = 32;
  localparam int NUM = 11;
  localparam int NB  = 4;

  typedef struct {
    logic [PS-1:0] v;
    logic [NB-1:0] i;
    int            cyc;
  } exp_t;

  logic          clk, reset, start;
  logic [PS-1:0] p_in;
  logic [NB-1:0] chose_index, max_index;
  logic          busy, done;
  logic [PS-1:0] max_value;

  logic [PS-1:0] store [0:NUM-1];
  exp_t          sbq [$];
  int            cyc;
  int            checks, failures;

  max_posibility_finder #(.p_size(PS), .POS_num(NUM), .POS_num_bit(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .P_in(p_in),
    .chose_index(chose_index), .busy(busy), .done(done),
    .max_value(max_value), .max_index(max_index)
  );

  assign p_in = (chose_index < NB'(NUM)) ? store[chose_index] : '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done === 1'b1) begin
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("max_value", max_value, e.v);
          chk("max_index", PS'(max_index), PS'(e.i));
          chk("done_latency", PS'(cyc), PS'(e.cyc));
        end
      end
    end
  endtask

  // pv/pi: result left by the previous scan, which must hold until index 0 is sampled.
  task automatic run_scan(input logic [PS-1:0] ev, input logic [NB-1:0] ei,
                          input logic [PS-1:0] pv, input logic [NB-1:0] pi, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.v = ev; e.i = ei; e.cyc = cyc + NUM + 1;
    sbq.push_back(e);
    for (int i = 0; i < NUM; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("chose_index", PS'(chose_index), PS'(i));
      chk("busy_scan", PS'(busy), 1);
      if (i == 0) begin
        chk("hold_value", max_value, pv);
        chk("hold_index", PS'(max_index), PS'(pi));
      end
    end
    @(negedge clk);
    chk("busy_done", PS'(busy), 1);
    @(negedge clk);
    chk("busy_idle", PS'(busy), 0);
    chk("idle_chose_index", PS'(chose_index), PS'(NUM - 1));
    chk("result_hold", max_value, ev);
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < NUM; i++) store[i] = '0;
    fork monitor(); join_none

    @(negedge clk);
    chk("rst_chose_index", PS'(chose_index), 0);
    chk("rst_busy", PS'(busy), 0);
    chk("rst_done", PS'(done), 0);
    chk("rst_max_value", max_value, 0);
    chk("rst_max_index", PS'(max_index), 0);
    reset = 1'b0;

    // Tie between entries 1 and 3 keeps index 1.
    store = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd0, 32'd1, 32'd2, 32'd7, 32'd8, 32'd4, 32'd6};
    run_scan(32'd9, 4'd1, 32'd0, 4'd0, 1'b0);

    // Back-to-back with new contents; previous 9/1 must hold into the new scan.
    for (int i = 0; i < NUM; i++) store[i] = '0;
    run_scan(32'd0, 4'd0, 32'd9, 4'd1, 1'b0);

    // Unsigned compare, maximum in the last entry.
    for (int i = 0; i < NUM; i++) store[i] = 32'h7FFF_FFFF;
    store[NUM-1] = 32'hFFFF_FFFF;
    run_scan(32'hFFFF_FFFF, 4'd10, 32'd0, 4'd0, 1'b0);

    // start held through the whole scan and the DONE cycle.
    store = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd0, 32'd1, 32'd2, 32'd7, 32'd8, 32'd4, 32'd6};
    run_scan(32'd9, 4'd1, 32'hFFFF_FFFF, 4'd10, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart_busy", PS'(busy), 0);
    end

    // Abort in the 5th SCAN cycle.
    store = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd10};
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_chose_index", PS'(chose_index), 0);
    chk("abort_busy", PS'(busy), 0);
    chk("abort_done", PS'(done), 0);
    chk("abort_max_value", max_value, 0);
    chk("abort_max_index", PS'(max_index), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (14) begin
      @(negedge clk);
      chk("abort_no_done", PS'(done), 0);
    end
    run_scan(32'd10, 4'd9, 32'd0, 4'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", PS'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
